// File: rtl/egress_pkg.sv
// Shared types, register map and helpers for the egress metadata
// statistics block.
package egress_pkg;

  localparam int NUM_PORTS = 4;

  typedef struct packed {
    logic [1:0]  dest;
    logic [1:0]  src;
    logic [21:0] time_delta;
    logic [5:0]  packet_len;
  } meta_t;

  localparam logic [3:0] ADDR_POP    = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_PKT    = 4'd2;
  localparam logic [3:0] ADDR_BLK    = 4'd6;
  localparam logic [3:0] ADDR_DELTA  = 4'd10;
  localparam logic [3:0] ADDR_DROP   = 4'd14;
  localparam logic [3:0] ADDR_CTRL   = 4'd15;

  // A zero length field encodes a full 64-block packet.
  function automatic logic [6:0] decode_blocks(
    input logic [5:0] len
  );
    return (len == 6'd0) ? 7'd64 : {1'b0, len};
  endfunction

endpackage

// File: rtl/meta_fifo.sv
// Count-based synchronous FIFO with registered pop data.
// A pop on an empty FIFO loads zero into dout.
module meta_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [31:0]            din,
  output logic [31:0]            dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_pop;
  logic          do_push;

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so push into a full FIFO is ok.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (pop)
        dout <= empty ? '0 : mem[head];
      if (do_pop)
        head <= head + AW'(1);
      if (do_push)
        tail <= tail + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[tail] <= din;
  end

endmodule

// File: rtl/egress_meta_stats.sv
// Egress metadata FIFO plus per-port packet/block/latency statistics
// behind a registered word-addressed register interface.
module egress_meta_stats
  import egress_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        meta_en,
  input  logic [31:0] meta_in,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        fifo_empty,
  output logic        fifo_full
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  meta_t          m;
  logic           pop_req;
  logic           clear;
  logic           drop;
  logic [31:0]    fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic [31:0]    pkt_cnt   [NUM_PORTS];
  logic [31:0]    blk_cnt   [NUM_PORTS];
  logic [21:0]    max_delta [NUM_PORTS];
  logic [15:0]    drop_cnt;
  logic [31:0]    reg_val;
  logic [3:0]     off;
  logic [31:0]    rd_q;
  logic           pop_sel;
  logic           unused_bits;

  assign m           = meta_t'(meta_in);
  assign unused_bits = ^{wr_data[31:1], m.src};

  assign pop_req = rd_en && addr == ADDR_POP;
  assign clear   = wr_en && !rd_en && addr == ADDR_CTRL && wr_data[0];
  assign drop    = meta_en && fifo_full && !pop_req;

  meta_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (meta_en),
    .pop   (pop_req),
    .din   (meta_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Clear takes priority over a same-cycle packet.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt[i]   <= '0;
        blk_cnt[i]   <= '0;
        max_delta[i] <= '0;
      end
      drop_cnt <= '0;
    end else if (meta_en) begin
      pkt_cnt[m.dest] <= pkt_cnt[m.dest] + 32'd1;
      blk_cnt[m.dest] <= blk_cnt[m.dest]
                         + 32'(decode_blocks(m.packet_len));
      if (m.time_delta > max_delta[m.dest])
        max_delta[m.dest] <= m.time_delta;
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Port groups are 4-aligned after subtracting 2, so the low bits index.
  always_comb begin
    reg_val = '0;
    off     = addr - ADDR_PKT;
    unique case (1'b1)
      addr == ADDR_STATUS:
        reg_val = {fifo_empty, fifo_full, 14'b0, 16'(fifo_count)};
      addr >= ADDR_PKT && addr < ADDR_BLK:
        reg_val = pkt_cnt[off[1:0]];
      addr >= ADDR_BLK && addr < ADDR_DELTA:
        reg_val = blk_cnt[off[1:0]];
      addr >= ADDR_DELTA && addr < ADDR_DROP:
        reg_val = {10'b0, max_delta[off[1:0]]};
      addr == ADDR_DROP:
        reg_val = {16'b0, drop_cnt};
      default:
        reg_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_q     <= '0;
      pop_sel  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        pop_sel <= pop_req;
        rd_q    <= reg_val;
      end
    end
  end

  // Pop data is already registered inside the FIFO.
  assign rd_data = pop_sel ? fifo_dout : rd_q;

endmodule
